// File: rtl/decode_scoreboard_stage_if.sv
// rtl/decode_scoreboard_stage_if.sv - fetch, register-file, execute and writeback signals of the decode stage
interface decode_scoreboard_stage_if #(
  parameter int WORD  = 32,
  parameter int ADDR  = 32,
  parameter int W_RD  = 5,
  parameter int W_IMM = 16,
  parameter int W_OPR = 32,
  parameter int W_OPC = WORD - 1 - 2 * W_RD - W_IMM
);
  logic             v_i;
  logic             ready_o;
  logic [WORD-1:0]  inst_i;
  logic [ADDR-1:0]  pc_i;
  logic [W_RD-1:0]  r0_o;
  logic [W_RD-1:0]  r1_o;
  logic [W_OPR-1:0] opr0_i;
  logic [W_OPR-1:0] opr1_i;
  logic             v_o;
  logic             stall_i;
  logic [ADDR-1:0]  pc_o;
  logic [W_OPC-1:0] opecode_o;
  logic [W_OPR-1:0] opr0_o;
  logic [W_OPR-1:0] opr1_o;
  logic [W_OPR-1:0] imm_o;
  logic             immf_o;
  logic             stf_o;
  logic             wb_o;
  logic [W_RD-1:0]  wb_r_o;
  logic             wbdone_i;
  logic [W_RD-1:0]  wbdone_r_i;
  logic             branch_i;
  logic             busy_o;

  modport slave (
    input  v_i, inst_i, pc_i, opr0_i, opr1_i, stall_i, wbdone_i, wbdone_r_i, branch_i,
    output ready_o, r0_o, r1_o, v_o, pc_o, opecode_o, opr0_o, opr1_o, imm_o,
           immf_o, stf_o, wb_o, wb_r_o, busy_o
  );

  modport master (
    output v_i, inst_i, pc_i, opr0_i, opr1_i, stall_i, wbdone_i, wbdone_r_i, branch_i,
    input  ready_o, r0_o, r1_o, v_o, pc_o, opecode_o, opr0_o, opr1_o, imm_o,
           immf_o, stf_o, wb_o, wb_r_o, busy_o
  );
endinterface

// File: rtl/decode_scoreboard_stage.sv
// rtl/decode_scoreboard_stage.sv - decode/issue stage with per-register pending-write counters
module decode_scoreboard_stage #(
  parameter int WORD     = 32,
  parameter int ADDR     = 32,
  parameter int W_RD     = 5,
  parameter int W_IMM    = 16,
  parameter int W_OPR    = 32,
  parameter int W_OPC    = WORD - 1 - 2 * W_RD - W_IMM,
  parameter int MAX_PEND = 3
) (
  input logic clk,
  input logic reset,
  decode_scoreboard_stage_if.slave bus
);
  localparam int NREG = 1 << W_RD;
  localparam int CW   = $clog2(MAX_PEND + 1);
  localparam int CW1  = CW + 1;

  localparam logic [W_OPC-1:0] OPC_ADD = W_OPC'(1);
  localparam logic [W_OPC-1:0] OPC_AND = W_OPC'(2);
  localparam logic [W_OPC-1:0] OPC_LI  = W_OPC'(3);
  localparam logic [W_OPC-1:0] OPC_ST  = W_OPC'(4);
  localparam logic [W_OPC-1:0] OPC_CMP = W_OPC'(5);

  // info = {stf, immf, sext, wreg}
  function automatic logic [3:0] decode_inst(input logic [W_OPC:0] om);
    logic [W_OPC-1:0] o;
    logic             m;
    {o, m} = om;
    case (o)
      OPC_ADD: decode_inst = {1'b0, m, m, 1'b1};
      OPC_AND: decode_inst = {1'b0, m, 1'b0, 1'b1};
      OPC_LI:  decode_inst = {1'b0, 1'b1, m, 1'b1};
      OPC_ST:  decode_inst = 4'b1110;
      OPC_CMP: decode_inst = {1'b0, m, m, 1'b0};
      default: decode_inst = 4'b0000;
    endcase
  endfunction

  logic [W_OPC-1:0] opc;
  logic             mode;
  logic [W_RD-1:0]  ra;
  logic [W_RD-1:0]  rb;
  logic [W_IMM-1:0] imm_f;
  logic [3:0]       info;
  logic [W_OPR-1:0] imm_ext;

  assign {opc, mode, ra, rb, imm_f} = bus.inst_i;
  assign info    = decode_inst({opc, mode});
  assign imm_ext = info[1] ? W_OPR'(signed'(imm_f)) : W_OPR'(imm_f);

  logic                      v_q, busy_q, immf_q, stf_q, wb_q;
  logic [ADDR-1:0]           pc_q;
  logic [W_OPC-1:0]          opc_q;
  logic [W_OPR-1:0]          opr0_q, opr1_q, imm_q;
  logic [W_RD-1:0]           wb_r_q;
  logic [NREG-1:0][CW-1:0]   pend_q, pend_d;

  // rA is a source only for non-writing ops; writers may stack up to MAX_PEND writes on rA.
  logic           rd_a, rd_b, src_pend, out_raw, full, hazard, ready, accept, dispatch;
  logic           inc_en, dec_en;
  logic [CW1-1:0] ra_inflight;

  assign rd_a        = ~info[0];
  assign rd_b        = ~info[2];
  assign src_pend    = (rd_a & (pend_q[ra] != '0)) | (rd_b & (pend_q[rb] != '0));
  assign out_raw     = v_q & wb_q & ((rd_a & (ra == wb_r_q)) | (rd_b & (rb == wb_r_q)));
  // The write sitting in the output register will be counted once it dispatches.
  assign ra_inflight = {1'b0, pend_q[ra]} + CW1'(v_q & wb_q & (ra == wb_r_q));
  assign full        = info[0] & (ra_inflight >= CW1'(MAX_PEND));
  assign hazard      = src_pend | out_raw | full;
  assign ready       = ~hazard & ~bus.branch_i & (~v_q | ~bus.stall_i);
  assign accept      = bus.v_i & ready;
  assign dispatch    = v_q & ~bus.stall_i;

  assign inc_en = dispatch & wb_q;
  assign dec_en = bus.wbdone_i & (pend_q[bus.wbdone_r_i] != '0);

  always_comb begin
    pend_d = pend_q;
    if (inc_en && !(dec_en && (bus.wbdone_r_i == wb_r_q)))
      pend_d[wb_r_q] = pend_q[wb_r_q] + CW'(1);
    if (dec_en && !(inc_en && (bus.wbdone_r_i == wb_r_q)))
      pend_d[bus.wbdone_r_i] = pend_q[bus.wbdone_r_i] - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_q    <= 1'b0;
      busy_q <= 1'b0;
      pend_q <= '0;
      pc_q   <= '0;
      opc_q  <= '0;
      opr0_q <= '0;
      opr1_q <= '0;
      imm_q  <= '0;
      immf_q <= 1'b0;
      stf_q  <= 1'b0;
      wb_q   <= 1'b0;
      wb_r_q <= '0;
    end else begin
      pend_q <= pend_d;
      busy_q <= |pend_d;
      if (accept) begin
        v_q    <= 1'b1;
        pc_q   <= bus.pc_i;
        opc_q  <= opc;
        opr0_q <= bus.opr0_i;
        opr1_q <= bus.opr1_i;
        imm_q  <= imm_ext;
        immf_q <= info[2];
        stf_q  <= info[3];
        wb_q   <= info[0];
        wb_r_q <= ra;
      end else if (dispatch || bus.branch_i) begin
        v_q <= 1'b0;
      end
    end
  end

  assign bus.ready_o   = ready;
  assign bus.r0_o      = ra;
  assign bus.r1_o      = rb;
  assign bus.v_o       = v_q;
  assign bus.pc_o      = pc_q;
  assign bus.opecode_o = opc_q;
  assign bus.opr0_o    = opr0_q;
  assign bus.opr1_o    = opr1_q;
  assign bus.imm_o     = imm_q;
  assign bus.immf_o    = immf_q;
  assign bus.stf_o     = stf_q;
  assign bus.wb_o      = wb_q;
  assign bus.wb_r_o    = wb_r_q;
  assign bus.busy_o    = busy_q;
endmodule

// File: tb/tb_decode_scoreboard_stage.sv
// tb/tb_decode_scoreboard_stage.sv - directed self-checking bench for decode_scoreboard_stage
module tb_decode_scoreboard_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int ntests = 0;
  int nfail = 0;

  decode_scoreboard_stage_if bus ();
  decode_scoreboard_stage dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  assign bus.opr0_i = 32'h1000_0000 | 32'(bus.r0_o);
  assign bus.opr1_i = 32'h2000_0000 | 32'(bus.r1_o);

  function automatic logic [31:0] mk(input logic [4:0] opc, input logic mode,
                                     input logic [4:0] ra, input logic [4:0] rb,
                                     input logic [15:0] imm);
    return {opc, mode, ra, rb, imm};
  endfunction

  task automatic idle();
    bus.v_i = 1'b0; bus.inst_i = '0; bus.pc_i = '0; bus.stall_i = 1'b0;
    bus.wbdone_i = 1'b0; bus.wbdone_r_i = '0; bus.branch_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle();
    repeat (2) @(negedge clk);
    ntests++; if (bus.v_o !== 1'b0) begin nfail++; $display("FAIL rst_v_o got %b exp 0", bus.v_o); end
    ntests++; if (bus.busy_o !== 1'b0) begin nfail++; $display("FAIL rst_busy got %b exp 0", bus.busy_o); end
    ntests++; if (bus.pc_o !== 32'h0) begin nfail++; $display("FAIL rst_pc got %h exp 0", bus.pc_o); end
    ntests++; if (dut.pend_q !== '0) begin nfail++; $display("FAIL rst_pend got %h exp 0", dut.pend_q); end
    reset = 1'b0;
  endtask

  task automatic test_issue();
    bus.v_i = 1'b1; bus.inst_i = mk(5'd1, 1'b0, 5'd3, 5'd4, 16'h0010); bus.pc_i = 32'h100; #1;
    ntests++; if (bus.ready_o !== 1'b1) begin nfail++; $display("FAIL t1_ready got %b exp 1", bus.ready_o); end
    ntests++; if (bus.r0_o !== 5'd3) begin nfail++; $display("FAIL t1_r0 got %0d exp 3", bus.r0_o); end
    ntests++; if (bus.r1_o !== 5'd4) begin nfail++; $display("FAIL t1_r1 got %0d exp 4", bus.r1_o); end
    @(negedge clk); bus.v_i = 1'b0;
    ntests++; if (bus.v_o !== 1'b1) begin nfail++; $display("FAIL t1_v_o got %b exp 1", bus.v_o); end
    ntests++; if (bus.opecode_o !== 5'd1) begin nfail++; $display("FAIL t1_opc got %0d exp 1", bus.opecode_o); end
    ntests++; if (bus.wb_r_o !== 5'd3 || bus.wb_o !== 1'b1) begin nfail++; $display("FAIL t1_wb got %b/%0d exp 1/3", bus.wb_o, bus.wb_r_o); end
    ntests++; if (bus.pc_o !== 32'h100) begin nfail++; $display("FAIL t1_pc got %h exp 100", bus.pc_o); end
    ntests++; if (bus.opr0_o !== 32'h1000_0003) begin nfail++; $display("FAIL t1_opr0 got %h exp 10000003", bus.opr0_o); end
    ntests++; if (bus.opr1_o !== 32'h2000_0004) begin nfail++; $display("FAIL t1_opr1 got %h exp 20000004", bus.opr1_o); end
    ntests++; if (bus.imm_o !== 32'h10 || bus.immf_o !== 1'b0) begin nfail++; $display("FAIL t1_imm got %h/%b exp 10/0", bus.imm_o, bus.immf_o); end
    @(negedge clk);
    ntests++; if (bus.v_o !== 1'b0) begin nfail++; $display("FAIL t1_v_o_after got %b exp 0", bus.v_o); end
    ntests++; if (dut.pend_q[3] !== 2'd1) begin nfail++; $display("FAIL t1_pend3 got %0d exp 1", dut.pend_q[3]); end
    ntests++; if (bus.busy_o !== 1'b1) begin nfail++; $display("FAIL t1_busy got %b exp 1", bus.busy_o); end
    bus.wbdone_i = 1'b1; bus.wbdone_r_i = 5'd3;
    @(negedge clk); bus.wbdone_i = 1'b0;
    ntests++; if (dut.pend_q[3] !== 2'd0 || bus.busy_o !== 1'b0) begin nfail++; $display("FAIL t1_retire got %0d/%b exp 0/0", dut.pend_q[3], bus.busy_o); end
  endtask

  task automatic test_back_to_back();
    bus.v_i = 1'b1; bus.inst_i = mk(5'd1, 1'b0, 5'd3, 5'd1, 16'h0); bus.pc_i = 32'h110;
    @(negedge clk);
    bus.inst_i = mk(5'd1, 1'b0, 5'd6, 5'd3, 16'h0); bus.pc_i = 32'h114; #1;
    ntests++; if (bus.ready_o !== 1'b0) begin nfail++; $display("FAIL t2_ready_out got %b exp 0", bus.ready_o); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      ntests++; if (bus.ready_o !== 1'b0 || bus.v_o !== 1'b0) begin nfail++; $display("FAIL t2_wait%0d got ready %b v_o %b exp 0 0", k, bus.ready_o, bus.v_o); end
    end
    bus.wbdone_i = 1'b1; bus.wbdone_r_i = 5'd3; #1;
    ntests++; if (bus.ready_o !== 1'b0) begin nfail++; $display("FAIL t2_ready_retire got %b exp 0", bus.ready_o); end
    @(negedge clk); bus.wbdone_i = 1'b0; #1;
    ntests++; if (bus.ready_o !== 1'b1) begin nfail++; $display("FAIL t2_ready_after got %b exp 1", bus.ready_o); end
    @(negedge clk); bus.v_i = 1'b0;
    ntests++; if (bus.v_o !== 1'b1 || bus.pc_o !== 32'h114) begin nfail++; $display("FAIL t2_issue got %b/%h exp 1/114", bus.v_o, bus.pc_o); end
    ntests++; if (bus.wb_r_o !== 5'd6 || bus.opr1_o !== 32'h2000_0003) begin nfail++; $display("FAIL t2_fields got %0d/%h exp 6/20000003", bus.wb_r_o, bus.opr1_o); end
    @(negedge clk); bus.wbdone_i = 1'b1; bus.wbdone_r_i = 5'd6;
    @(negedge clk); bus.wbdone_i = 1'b0;
    ntests++; if (bus.busy_o !== 1'b0) begin nfail++; $display("FAIL t2_busy got %b exp 0", bus.busy_o); end
  endtask

  task automatic test_pend_limit();
    bus.v_i = 1'b1; bus.inst_i = mk(5'd3, 1'b0, 5'd5, 5'd0, 16'h1); bus.pc_i = 32'h200; #1;
    ntests++; if (bus.ready_o !== 1'b1) begin nfail++; $display("FAIL t3_ready0 got %b exp 1", bus.ready_o); end
    @(negedge clk); bus.pc_i = 32'h204; #1;
    ntests++; if (bus.ready_o !== 1'b1) begin nfail++; $display("FAIL t3_ready1 got %b exp 1", bus.ready_o); end
    @(negedge clk); bus.pc_i = 32'h208; #1;
    ntests++; if (bus.ready_o !== 1'b1) begin nfail++; $display("FAIL t3_ready2 got %b exp 1", bus.ready_o); end
    @(negedge clk); bus.pc_i = 32'h20C; #1;
    ntests++; if (bus.ready_o !== 1'b0) begin nfail++; $display("FAIL t3_ready3 got %b exp 0", bus.ready_o); end
    ntests++; if (bus.pc_o !== 32'h208 || bus.v_o !== 1'b1) begin nfail++; $display("FAIL t3_third got %h/%b exp 208/1", bus.pc_o, bus.v_o); end
    @(negedge clk); #1;
    ntests++; if (dut.pend_q[5] !== 2'd3) begin nfail++; $display("FAIL t3_pend_full got %0d exp 3", dut.pend_q[5]); end
    ntests++; if (bus.ready_o !== 1'b0 || bus.v_o !== 1'b0) begin nfail++; $display("FAIL t3_held got ready %b v_o %b exp 0 0", bus.ready_o, bus.v_o); end
    @(negedge clk); #1;
    ntests++; if (bus.ready_o !== 1'b0) begin nfail++; $display("FAIL t3_held2 got %b exp 0", bus.ready_o); end
    bus.wbdone_i = 1'b1; bus.wbdone_r_i = 5'd5;
    @(negedge clk); bus.wbdone_i = 1'b0; #1;
    ntests++; if (dut.pend_q[5] !== 2'd2 || bus.ready_o !== 1'b1) begin nfail++; $display("FAIL t3_retire got %0d/%b exp 2/1", dut.pend_q[5], bus.ready_o); end
    @(negedge clk); bus.v_i = 1'b0;
    ntests++; if (bus.v_o !== 1'b1 || bus.pc_o !== 32'h20C) begin nfail++; $display("FAIL t3_fourth got %b/%h exp 1/20C", bus.v_o, bus.pc_o); end
    @(negedge clk);
    ntests++; if (dut.pend_q[5] !== 2'd3) begin nfail++; $display("FAIL t3_pend_refill got %0d exp 3", dut.pend_q[5]); end
    bus.wbdone_i = 1'b1; bus.wbdone_r_i = 5'd5;
    for (int k = 2; k >= 0; k--) begin
      @(negedge clk);
      ntests++; if (dut.pend_q[5] !== 2'(k)) begin nfail++; $display("FAIL t3_drain got %0d exp %0d", dut.pend_q[5], k); end
    end
    @(negedge clk); bus.wbdone_i = 1'b0;
    ntests++; if (dut.pend_q[5] !== 2'd0 || bus.busy_o !== 1'b0) begin nfail++; $display("FAIL t3_zero_retire got %0d/%b exp 0/0", dut.pend_q[5], bus.busy_o); end
  endtask

  task automatic test_stall_hold();
    bus.v_i = 1'b1; bus.inst_i = mk(5'd1, 1'b1, 5'd7, 5'd9, 16'h1234); bus.pc_i = 32'h300; bus.stall_i = 1'b1; #1;
    ntests++; if (bus.ready_o !== 1'b1) begin nfail++; $display("FAIL t4_ready_empty got %b exp 1", bus.ready_o); end
    @(negedge clk);
    bus.inst_i = mk(5'd1, 1'b0, 5'd8, 5'd9, 16'h0); bus.pc_i = 32'h304;
    ntests++; if (bus.immf_o !== 1'b1) begin nfail++; $display("FAIL t4_immf got %b exp 1", bus.immf_o); end
    for (int k = 0; k < 4; k++) begin
      #1;
      ntests++; if (bus.ready_o !== 1'b0) begin nfail++; $display("FAIL t4_ready%0d got %b exp 0", k, bus.ready_o); end
      @(negedge clk);
      ntests++; if (bus.v_o !== 1'b1 || bus.pc_o !== 32'h300 || bus.opr0_o !== 32'h1000_0007 || bus.imm_o !== 32'h1234)
        begin nfail++; $display("FAIL t4_hold%0d got %b %h %h %h exp 1 300 10000007 1234", k, bus.v_o, bus.pc_o, bus.opr0_o, bus.imm_o); end
    end
    bus.stall_i = 1'b0; bus.v_i = 1'b0;
    @(negedge clk);
    ntests++; if (bus.v_o !== 1'b0 || dut.pend_q[7] !== 2'd1) begin nfail++; $display("FAIL t4_dispatch got %b/%0d exp 0/1", bus.v_o, dut.pend_q[7]); end
    bus.wbdone_i = 1'b1; bus.wbdone_r_i = 5'd7;
    @(negedge clk); bus.wbdone_i = 1'b0;
  endtask

  task automatic test_flush();
    bus.v_i = 1'b1; bus.inst_i = mk(5'd3, 1'b0, 5'd10, 5'd0, 16'h55); bus.pc_i = 32'h400; bus.stall_i = 1'b1;
    @(negedge clk);
    ntests++; if (bus.v_o !== 1'b1 || bus.wb_r_o !== 5'd10) begin nfail++; $display("FAIL t5_load got %b/%0d exp 1/10", bus.v_o, bus.wb_r_o); end
    bus.branch_i = 1'b1; bus.inst_i = mk(5'd3, 1'b0, 5'd11, 5'd0, 16'h66); bus.pc_i = 32'h404; #1;
    ntests++; if (bus.ready_o !== 1'b0) begin nfail++; $display("FAIL t5_ready got %b exp 0", bus.ready_o); end
    @(negedge clk); bus.branch_i = 1'b0; bus.v_i = 1'b0; bus.stall_i = 1'b0;
    ntests++; if (bus.v_o !== 1'b0 || bus.pc_o !== 32'h400) begin nfail++; $display("FAIL t5_flush got %b/%h exp 0/400", bus.v_o, bus.pc_o); end
    ntests++; if (dut.pend_q[10] !== 2'd0 || dut.pend_q[11] !== 2'd0 || bus.busy_o !== 1'b0)
      begin nfail++; $display("FAIL t5_pend got %0d/%0d/%b exp 0/0/0", dut.pend_q[10], dut.pend_q[11], bus.busy_o); end
    bus.v_i = 1'b1; bus.inst_i = mk(5'd3, 1'b0, 5'd12, 5'd0, 16'h77); bus.pc_i = 32'h408;
    @(negedge clk); bus.v_i = 1'b0; bus.branch_i = 1'b1;
    ntests++; if (bus.v_o !== 1'b1) begin nfail++; $display("FAIL t5_load2 got %b exp 1", bus.v_o); end
    @(negedge clk); bus.branch_i = 1'b0;
    ntests++; if (bus.v_o !== 1'b0 || dut.pend_q[12] !== 2'd1) begin nfail++; $display("FAIL t5_flush_dispatch got %b/%0d exp 0/1", bus.v_o, dut.pend_q[12]); end
    bus.wbdone_i = 1'b1; bus.wbdone_r_i = 5'd12;
    @(negedge clk); bus.wbdone_i = 1'b0;
    ntests++; if (bus.busy_o !== 1'b0) begin nfail++; $display("FAIL t5_busy got %b exp 0", bus.busy_o); end
  endtask

  task automatic test_imm_reset();
    bus.v_i = 1'b1; bus.inst_i = mk(5'd3, 1'b1, 5'd1, 5'd0, 16'h8001); bus.pc_i = 32'h500;
    @(negedge clk);
    bus.inst_i = mk(5'd3, 1'b0, 5'd2, 5'd0, 16'h8001); bus.pc_i = 32'h504;
    ntests++; if (bus.imm_o !== 32'hFFFF_8001) begin nfail++; $display("FAIL t6_sext got %h exp FFFF8001", bus.imm_o); end
    @(negedge clk); bus.v_i = 1'b0; bus.stall_i = 1'b1;
    ntests++; if (bus.imm_o !== 32'h0000_8001 || bus.wb_r_o !== 5'd2) begin nfail++; $display("FAIL t6_zext got %h/%0d exp 00008001/2", bus.imm_o, bus.wb_r_o); end
    @(negedge clk);
    ntests++; if (bus.v_o !== 1'b1 || bus.busy_o !== 1'b1) begin nfail++; $display("FAIL t6_held got %b/%b exp 1/1", bus.v_o, bus.busy_o); end
    reset = 1'b1; bus.v_i = 1'b1; bus.inst_i = mk(5'd1, 1'b0, 5'd4, 5'd5, 16'h9);
    @(negedge clk); reset = 1'b0; idle();
    ntests++; if (bus.v_o !== 1'b0 || bus.busy_o !== 1'b0) begin nfail++; $display("FAIL t6_rst_v got %b/%b exp 0/0", bus.v_o, bus.busy_o); end
    ntests++; if (bus.pc_o !== 32'h0 || bus.imm_o !== 32'h0 || bus.opr0_o !== 32'h0 || bus.opr1_o !== 32'h0)
      begin nfail++; $display("FAIL t6_rst_data got %h %h %h %h exp 0", bus.pc_o, bus.imm_o, bus.opr0_o, bus.opr1_o); end
    ntests++; if (bus.opecode_o !== 5'd0 || bus.wb_r_o !== 5'd0 || bus.wb_o !== 1'b0 || bus.immf_o !== 1'b0 || bus.stf_o !== 1'b0)
      begin nfail++; $display("FAIL t6_rst_ctl got %0d %0d %b %b %b exp 0", bus.opecode_o, bus.wb_r_o, bus.wb_o, bus.immf_o, bus.stf_o); end
    ntests++; if (dut.pend_q !== '0) begin nfail++; $display("FAIL t6_rst_pend got %h exp 0", dut.pend_q); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_issue();
    test_back_to_back();
    test_pend_limit();
    test_stall_hold();
    test_flush();
    test_imm_reset();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
